// File: rtl/cfg_frame_writer.sv
// cfg_frame_writer: streams bitstream bits into a frame/bit addressed configuration memory, one write per two cycles.
// Optional feature macro CFG_WRITER_PARITY_EN adds a trailing even-parity bit check after the last frame.
module cfg_frame_writer #(
  parameter int NUM_FRAMES = 11,
  parameter int FRAME_BITS = 6,
  parameter int BIT_AW     = 3,
  parameter int FRAME_AW   = 4
) (
  input  logic                           prog_clk,
  input  logic                           pReset,
  input  logic                           start,
  input  logic                           bit_valid,
  input  logic                           bit_data,
  output logic                           bit_ready,
  output logic                           enable,
  output logic [0:BIT_AW+FRAME_AW-1]     address,
  output logic [0:0]                     data_in,
  output logic                           busy,
  output logic                           done,
  output logic                           error
);

`ifdef CFG_WRITER_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, PARITY, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

  state_t                       r_state;
  state_t                       w_next;
  logic [BIT_AW-1:0]            r_bitIdx;
  logic [FRAME_AW-1:0]          r_frameIdx;
  logic [0:BIT_AW+FRAME_AW-1]   r_address;
  logic                         r_data;
  logic                         w_lastBit;
  logic                         w_lastFrame;

  assign w_lastBit   = (r_bitIdx == BIT_AW'(FRAME_BITS - 1));
  assign w_lastFrame = (r_frameIdx == FRAME_AW'(NUM_FRAMES - 1));
  assign address     = r_address;
  assign data_in     = r_data;

  always_comb begin
    w_next    = r_state;
    bit_ready = 1'b0;
    enable    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (bit_valid) w_next = WRITE;
      end
      WRITE: begin
        enable = 1'b1;
        busy   = 1'b1;
        if (w_lastBit && w_lastFrame) begin
`ifdef CFG_WRITER_PARITY_EN
          w_next = PARITY;
`else
          w_next = DONE;
`endif
        end else begin
          w_next = LOAD;
        end
      end
`ifdef CFG_WRITER_PARITY_EN
      PARITY: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
        if (bit_valid) w_next = DONE;
      end
`endif
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Address and data are captured at acceptance so they stay put through WRITE and the cycle after it.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state    <= IDLE;
      r_bitIdx   <= '0;
      r_frameIdx <= '0;
      r_address  <= '0;
      r_data     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_bitIdx   <= '0;
        r_frameIdx <= '0;
      end
      if (r_state == LOAD && bit_valid) begin
        r_address <= {r_bitIdx, r_frameIdx};
        r_data    <= bit_data;
      end
      if (r_state == WRITE) begin
        if (w_lastBit) begin
          r_bitIdx   <= '0;
          r_frameIdx <= r_frameIdx + FRAME_AW'(1);
        end else begin
          r_bitIdx <= r_bitIdx + BIT_AW'(1);
        end
      end
    end
  end

`ifdef CFG_WRITER_PARITY_EN
  logic r_parity;
  logic r_error;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_parity <= 1'b0;
      r_error  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_parity <= 1'b0;
      r_error  <= 1'b0;
    end else if (r_state == LOAD && bit_valid) begin
      r_parity <= r_parity ^ bit_data;
    end else if (r_state == PARITY && bit_valid) begin
      r_error <= r_error | (r_parity ^ bit_data);
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_frame_writer.sv
// tb_cfg_frame_writer: randomized sweeps against a queue-based reference of the frame/bit write order.
// Covers reset, stalls, start noise, mid-sweep abort, a reduced-size instance and, with CFG_WRITER_PARITY_EN, parity.
module tb_cfg_frame_writer;
  localparam int NF = 11, FB = 6, BAW = 3, FAW = 4, AW = BAW + FAW, TOTAL = NF * FB;
`ifdef CFG_WRITER_PARITY_EN
  localparam int DONE_LAT = TOTAL * 2 + 1;
`else
  localparam int DONE_LAT = TOTAL * 2;
`endif

  logic prog_clk = 1'b0;
  logic pReset = 1'b1, start = 1'b0, bit_valid = 1'b0, bit_data = 1'b0;
  logic bit_ready, enable, busy, done, error;
  logic [0:AW-1] address;
  logic [0:0] data_in;

  logic sStart = 1'b0, sValid = 1'b0, sData = 1'b0;
  logic sReady, sEnable, sBusy, sDone, sError;
  logic [0:AW-1] sAddress;
  logic [0:0] sDataIn;

  int tests = 0;
  int fails = 0;

  always #5 prog_clk = ~prog_clk;

  cfg_frame_writer dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .bit_valid(bit_valid), .bit_data(bit_data),
    .bit_ready(bit_ready), .enable(enable), .address(address), .data_in(data_in),
    .busy(busy), .done(done), .error(error)
  );

  cfg_frame_writer #(.NUM_FRAMES(2), .FRAME_BITS(2), .BIT_AW(3), .FRAME_AW(4)) dutSmall (
    .prog_clk(prog_clk), .pReset(pReset), .start(sStart), .bit_valid(sValid), .bit_data(sData),
    .bit_ready(sReady), .enable(sEnable), .address(sAddress), .data_in(sDataIn),
    .busy(sBusy), .done(sDone), .error(sError)
  );

  // Logical address = frame * 2**BIT_AW + bit, decoded from the bit field (address[0:BAW-1]) and frame field.
  function automatic logic [31:0] decodeAddr(input logic [0:AW-1] a);
    return {25'b0, a[BAW:AW-1], a[0:BAW-1]};
  endfunction

  function automatic logic [31:0] expAddr(input int k, input int fb);
    return 32'((k / fb) * (1 << BAW) + (k % fb));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_enable"}, enable, 0);
    checkOutput({pfx, "_address"}, 32'(address), 0);
    checkOutput({pfx, "_data_in"}, data_in, 0);
    checkOutput({pfx, "_bit_ready"}, bit_ready, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_done"}, done, 0);
    checkOutput({pfx, "_error"}, error, 0);
  endtask

  // One sweep on the default-size instance; abortAt >= 0 pulses pReset during that write.
  task automatic applyStimulus(input int stallPct, input bit startNoise, input int abortAt,
                               input bit allOnes, input logic parityBit);
    logic expBits[$];
    logic expErr = 1'b0;
    logic [31:0] holdAddr = '0;
    logic holdData = 1'b0;
    bit pendWrite = 0, doneDue = 0, holdCheck = 0, finished = 0, expEn, expDn;
    int acc = 0, writes = 0, cyc = 0, firstAcc = -1, bad;

    @(negedge prog_clk);
    start = 1'b1;
    bit_valid = 1'b0;
    @(negedge prog_clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("error_cleared_by_start", error, 0);

    while (!finished && cyc < 2000) begin
      @(negedge prog_clk);
      cyc++;
      expEn = pendWrite;
      pendWrite = 0;
      expDn = doneDue;
      doneDue = 0;
      checkOutput("enable", enable, 32'(expEn));
      checkOutput("done", done, 32'(expDn));
      checkOutput("busy", busy, 32'(!expDn));
      checkOutput("bit_ready", bit_ready, 32'(!(expEn || expDn)));

      if (enable) begin
        checkOutput($sformatf("addr_w%0d", writes), decodeAddr(address), expAddr(writes, FB));
        checkOutput($sformatf("data_w%0d", writes), data_in, (writes < expBits.size()) ? 32'(expBits[writes]) : 32'hx);
        holdAddr = decodeAddr(address);
        holdData = data_in[0];
        holdCheck = 1;
`ifndef CFG_WRITER_PARITY_EN
        if (writes == TOTAL - 1) doneDue = 1;
`endif
        writes++;
        if (abortAt >= 0 && writes - 1 == abortAt) begin
          pReset = 1'b1;
          start = 1'b0;
          bit_valid = 1'b0;
          @(negedge prog_clk);
          checkAllZero("abort");
          pReset = 1'b0;
          bad = 0;
          repeat (20) begin
            @(negedge prog_clk);
            if (enable !== 1'b0 || done !== 1'b0) bad++;
          end
          checkOutput("quiet_after_abort", bad, 0);
          return;
        end
      end else if (holdCheck) begin
        checkOutput("addr_hold", decodeAddr(address), holdAddr);
        checkOutput("data_hold", data_in, 32'(holdData));
        holdCheck = 0;
      end

      if (expDn) begin
        checkOutput("write_count", writes, TOTAL);
        checkOutput("error_at_done", error, 32'(expErr));
        if (stallPct == 0) checkOutput("done_latency", cyc - firstAcc, DONE_LAT);
        finished = 1;
      end

      start = (startNoise && busy === 1'b1 && !expDn && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      if (bit_ready === 1'b1 && !expDn) begin
        bit_valid = ($urandom_range(0, 99) >= stallPct) ? 1'b1 : 1'b0;
        bit_data = (acc < TOTAL) ? (allOnes ? 1'b1 : 1'($urandom_range(0, 1))) : parityBit;
        if (bit_valid) begin
          if (acc < TOTAL) begin
            expBits.push_back(bit_data);
            pendWrite = 1;
          end else begin
            expErr = (^{expBits.xor(), 1'b0}) ^ bit_data;
            doneDue = 1;
          end
          if (firstAcc < 0) firstAcc = cyc;
          acc++;
        end
      end else begin
        bit_valid = 1'($urandom_range(0, 1));
      end
    end
    checkOutput("sweep_finished", finished, 1);
    bit_valid = 1'b0;
    start = 1'b0;
    @(negedge prog_clk);
    checkOutput("idle_busy", busy, 0);
    checkOutput("error_sticky", error, 32'(expErr));
    repeat (3) @(negedge prog_clk);
    checkOutput("error_still_sticky", error, 32'(expErr));
  endtask

  initial begin
    logic [31:0] seen[$];
    logic [31:0] smallExp[4];
    bit sawDone;

    repeat (3) @(negedge prog_clk);
    checkAllZero("reset");
    pReset = 1'b0;

    applyStimulus(0, 0, -1, 0, 1'($urandom_range(0, 1)));
    applyStimulus(40, 1, -1, 0, 1'($urandom_range(0, 1)));
    applyStimulus(20, 0, 4 * FB + 2, 0, 1'b0);
    applyStimulus(0, 1, -1, 0, 1'($urandom_range(0, 1)));
`ifdef CFG_WRITER_PARITY_EN
    applyStimulus(0, 0, -1, 1, 1'b0);
    applyStimulus(10, 0, -1, 1, 1'b1);
    applyStimulus(0, 0, -1, 0, 1'($urandom_range(0, 1)));
`endif

    smallExp[0] = 32'h00;
    smallExp[1] = 32'h01;
    smallExp[2] = 32'h08;
    smallExp[3] = 32'h09;
    sawDone = 0;
    @(negedge prog_clk);
    sStart = 1'b1;
    @(negedge prog_clk);
    sStart = 1'b0;
    sValid = 1'b1;
    sData = 1'b0;
    for (int i = 0; i < 100 && !sawDone; i++) begin
      @(negedge prog_clk);
      if (sEnable === 1'b1) begin
        seen.push_back(decodeAddr(sAddress));
        checkOutput("small_data", sDataIn, 0);
      end
      if (sDone === 1'b1) sawDone = 1;
    end
    sValid = 1'b0;
    checkOutput("small_done", sawDone, 1);
    checkOutput("small_count", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("small_addr%0d", i), (i < seen.size()) ? seen[i] : 32'hx, smallExp[i]);
    @(negedge prog_clk);
    checkOutput("small_idle_busy", sBusy, 0);
    checkOutput("small_idle_ready", sReady, 0);
    checkOutput("small_error", sError, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
